// File: rtl/mix_agc_pkg.sv
// Shared types and helpers for the mixer-path AGC sequencer.
// Holds the FSM state encoding, the VGA code range and the sample-magnitude conversion.
package mix_agc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DECIDE  = 2'd2,
    ST_SETTLE  = 2'd3
  } agc_state_e;

  localparam int VGA_W = 3;
  localparam logic [VGA_W-1:0] VGA_MAX = 3'd7;
  localparam int MAG_W = 7;

  // Offset-binary sample to distance from mid-scale: 0x80/0x7F -> 0, 0xFF/0x00 -> 127.
  function automatic logic [MAG_W-1:0] sample_mag(input logic [7:0] sample);
    return sample[7] ? sample[6:0] : ~sample[6:0];
  endfunction

endpackage

// File: rtl/mix_peak_tracker.sv
// Running peak magnitude and full-scale (clip) counter for one measurement window.
// clear_i wins over accept_i; clip_reach_o flags the accept that brings the count to CLIP_CNT.
module mix_peak_tracker
  import mix_agc_pkg::*;
#(
  parameter logic [7:0] CLIP_CNT = 8'd8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept_i,
  input  logic             clear_i,
  input  logic [7:0]       digital_in_i,
  output logic [MAG_W-1:0] peak_o,
  output logic             clip_hit_o,
  output logic             clip_reach_o
);

  logic [MAG_W-1:0] mag;
  logic             is_full;
  logic [MAG_W-1:0] peak_q, peak_d;
  logic [7:0]       clip_cnt_q, clip_cnt_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    mag        = sample_mag(digital_in_i);
    is_full    = &mag;
    peak_d     = peak_q;
    clip_cnt_d = clip_cnt_q;
    if (clear_i) begin
      peak_d     = '0;
      clip_cnt_d = '0;
    end else if (accept_i) begin
      if (mag > peak_q) peak_d = mag;
      if (is_full && (clip_cnt_q != 8'hFF)) clip_cnt_d = clip_cnt_q + 8'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  // NOTE: only the async reset clears these flops; there is no memory array needing a reset loop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q     <= '0;
      clip_cnt_q <= '0;
    end else begin
      peak_q     <= peak_d;
      clip_cnt_q <= clip_cnt_d;
    end
  end

  assign peak_o       = peak_q;
  assign clip_hit_o   = (clip_cnt_q >= CLIP_CNT);
  assign clip_reach_o = (clip_cnt_d >= CLIP_CNT);

endmodule

// File: rtl/mix_agc_controller.sv
// Closed-loop AGC sequencer: windowed peak measurement, one-LSB hysteretic VGA steps,
// fast clip attack, and a settle interval after every gain change.
module mix_agc_controller
  import mix_agc_pkg::*;
#(
  parameter logic [15:0] WIN_LEN    = 16'd800,
  parameter logic [15:0] SETTLE_LEN = 16'd64,
  parameter logic [6:0]  HI_THRESH  = 7'd100,
  parameter logic [6:0]  LO_THRESH  = 7'd32,
  parameter logic [7:0]  CLIP_CNT   = 8'd8,
  parameter logic [2:0]  GAIN_INIT  = 3'd3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             agc_enable,
  input  logic             hold,
  input  logic             sample_valid,
  input  logic [7:0]       digital_in,
  output logic [VGA_W-1:0] vga_control,
  output logic             gain_changed,
  output logic             locked,
  output logic [MAG_W-1:0] peak_out,
  output logic [1:0]       agc_state
);

  localparam int MAX_LEN = (WIN_LEN > SETTLE_LEN) ? int'(WIN_LEN) : int'(SETTLE_LEN);
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WIN_LEN - 16'd1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_LEN - 16'd1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  agc_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [VGA_W-1:0] vga_q;
  logic             gain_changed_q;
  logic             locked_q;
  logic [MAG_W-1:0] peak_out_q;

  logic             accept;
  logic             clear;
  logic             attack;
  logic [MAG_W-1:0] peak;
  logic             clip_hit;
  logic             clip_reach;

  // The window is only live in MEASURE; every other state holds the tracker cleared.
  assign accept = agc_enable && (state_q == ST_MEASURE) && sample_valid && !hold;
  assign clear  = (state_q != ST_MEASURE);
  assign attack = clip_hit || (peak >= HI_THRESH);

  mix_peak_tracker #(
    .CLIP_CNT(CLIP_CNT)
  ) u_peak (
    .clk         (clk),
    .rst_n       (rst_n),
    .accept_i    (accept),
    .clear_i     (clear),
    .digital_in_i(digital_in),
    .peak_o      (peak),
    .clip_hit_o  (clip_hit),
    .clip_reach_o(clip_reach)
  );

  // One counter serves both the window and the settle interval; it is zeroed on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      vga_q          <= GAIN_INIT;
      gain_changed_q <= 1'b0;
      locked_q       <= 1'b0;
      peak_out_q     <= '0;
    end else begin
      gain_changed_q <= 1'b0;
      if (!agc_enable) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_MEASURE;
            cnt_q   <= '0;
          end
          ST_MEASURE: begin
            if (accept) begin
              if ((cnt_q == WIN_LAST) || clip_reach) begin
                state_q <= ST_DECIDE;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + CNT_ONE;
              end
            end
          end
          ST_DECIDE: begin
            peak_out_q <= peak;
            cnt_q      <= '0;
            if (attack && (vga_q != VGA_MAX)) begin
              vga_q          <= vga_q + 3'd1;
              gain_changed_q <= 1'b1;
              locked_q       <= 1'b0;
              state_q        <= ST_SETTLE;
            end else if (!attack && (peak < LO_THRESH) && (vga_q != '0)) begin
              vga_q          <= vga_q - 3'd1;
              gain_changed_q <= 1'b1;
              locked_q       <= 1'b0;
              state_q        <= ST_SETTLE;
            end else begin
              // Saturated requests land here too; they are never in range, so locked drops.
              locked_q <= !attack && (peak >= LO_THRESH);
              state_q  <= ST_MEASURE;
            end
          end
          ST_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
              state_q <= ST_MEASURE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign vga_control  = vga_q;
  assign gain_changed = gain_changed_q;
  assign locked       = locked_q;
  assign peak_out     = peak_out_q;
  assign agc_state    = state_q;

endmodule
